// File: rtl/seq_signed_div_pkg.sv
// Shared types and constants for the sequential signed divider.
// LATENCY is the number of clock edges from start acceptance to valid.
package div_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } state_t;

    function automatic int latency_of(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int width);
        return clog2(2 * width);
    endfunction

    localparam int LATENCY = latency_of(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_signed_div_if.sv
// Start/valid handshake bundle between a requester (master) and the divider (slave).
interface seq_signed_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 valid;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 dz;
    logic                 ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, valid, quotient, remainder, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, valid, quotient, remainder, dz, ovf
    );

endinterface

// File: rtl/seq_signed_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude if it fits.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] rem_in,
    input  logic           bit_in,
    input  logic [WIDTH:0] dmag,
    output logic [WIDTH:0] rem_out,
    output logic           q_bit
);

    logic           borrow;
    logic [WIDTH:0] diff;

    // rem_in is always below dmag, so its top bit is zero and the shift never loses data
    assign {borrow, diff} = {rem_in, bit_in} - {1'b0, dmag};
    assign q_bit          = ~borrow;
    assign rem_out        = q_bit ? diff : {rem_in[WIDTH-1:0], bit_in};

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle truncating signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// sign-magnitude restoring algorithm with a fixed start-to-valid latency.
module seq_signed_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_signed_div_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     res_quot_q, res_quot_d;
    logic [WIDTH-1:0]     res_rem_q, res_rem_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       prem_q, prem_d;
    logic [WIDTH:0]       dmag_q, dmag_d;
    logic                 sign_quot_q, sign_quot_d;
    logic                 sign_rem_q, sign_rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH:0]       step_rem;
    logic                 step_qbit;
    logic [2*WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]     rem_signed;
    logic [WIDTH:0]       quot_upper;
    logic                 quot_fits;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (prem_q),
        .bit_in  (acc_q[2*WIDTH-1]),
        .dmag    (dmag_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    assign quot_signed = sign_quot_q ? -acc_q : acc_q;
    assign rem_signed  = sign_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
    // The quotient fits in WIDTH bits only if everything above the WIDTH-bit sign bit is a sign copy
    assign quot_upper  = quot_signed[2*WIDTH-1:WIDTH-1];
    assign quot_fits   = (&quot_upper) | ~(|quot_upper);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        res_quot_d  = res_quot_q;
        res_rem_d   = res_rem_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        acc_d       = acc_q;
        prem_d      = prem_q;
        dmag_d      = dmag_q;
        sign_quot_d = sign_quot_q;
        sign_rem_d  = sign_rem_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                // Unsigned 2*WIDTH-bit negation maps -2^(2W-1) onto its correct magnitude
                acc_d       = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
                dmag_d      = {1'b0, (dvs_q[WIDTH-1] ? -dvs_q : dvs_q)};
                sign_quot_d = dvd_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];
                sign_rem_d  = dvd_q[2*WIDTH-1];
                prem_d      = '0;
                cnt_d       = '0;
                state_d     = DIV;
            end
            DIV: begin
                prem_d = step_rem;
                acc_d  = {acc_q[2*WIDTH-2:0], step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                if (dvs_q == '0) begin
                    res_quot_d = '0;
                    res_rem_d  = '0;
                    dz_d       = 1'b1;
                    ovf_d      = 1'b0;
                end else begin
                    res_quot_d = quot_signed[WIDTH-1:0];
                    res_rem_d  = rem_signed;
                    dz_d       = 1'b0;
                    ovf_d      = ~quot_fits;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            res_quot_q  <= '0;
            res_rem_q   <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            acc_q       <= '0;
            prem_q      <= '0;
            dmag_q      <= '0;
            sign_quot_q <= 1'b0;
            sign_rem_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            res_quot_q  <= res_quot_d;
            res_rem_q   <= res_rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            acc_q       <= acc_d;
            prem_q      <= prem_d;
            dmag_q      <= dmag_d;
            sign_quot_q <= sign_quot_d;
            sign_rem_q  <= sign_rem_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.quotient  = res_quot_q;
    assign bus.remainder = res_rem_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Scoreboard bench for seq_signed_div: directed vectors, control abuse, mid-op reset
// and a full multiply/divide round trip over all 6-bit operand pairs.
module tb_seq_signed_div;

    localparam int W   = div_pkg::DEFAULT_WIDTH;
    localparam int LAT = div_pkg::LATENCY;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           issue;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_signed_div_if #(.WIDTH(W)) bus ();

    seq_signed_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("quotient", 32'(bus.quotient), 32'(mon_e.q));
                checkOutput("remainder", 32'(bus.remainder), 32'(mon_e.r));
                checkOutput("dz", 32'(bus.dz), 32'(mon_e.dz));
                checkOutput("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
                checkOutput("busy_at_valid", 32'(bus.busy), 32'd0);
                checkOutput("latency", 32'(cyc - mon_e.issue), 32'(LAT));
            end
        end
    end

    // mode 0: plain op, 1: start re-pulsed while busy, 2: reset asserted mid-operation
    task automatic applyStimulus(input int dvd, input int dvs, input int eq, input int er,
                                 input bit edz, input bit eovf, input int mode);
        exp_t e;
        bit   got;
        bus.dividend = dvd[2*W-1:0];
        bus.divisor  = dvs[W-1:0];
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.q     = eq[W-1:0];
        e.r     = er[W-1:0];
        e.dz    = edz;
        e.ovf   = eovf;
        e.issue = cyc;
        if (mode != 2) sb.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (mode == 1) begin
                bus.start    = (k == 3) || (k == 13);
                bus.dividend = 12'($urandom);
                bus.divisor  = 6'($urandom);
            end
            if (mode == 2) begin
                if (k == 5) rst_n = 1'b0;
                if (k == 6) begin
                    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
                    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
                    checkOutput("rst_quotient", 32'(bus.quotient), 32'd0);
                    checkOutput("rst_remainder", 32'(bus.remainder), 32'd0);
                    checkOutput("rst_dz", 32'(bus.dz), 32'd0);
                    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
                end
                if (k == 7) rst_n = 1'b1;
            end else if (bus.valid) begin
                got = 1'b1;
                break;
            end
        end
        if (mode != 2 && !got) checkOutput("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_valid", 32'(bus.valid), 32'd0);
        checkOutput("reset_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset_dz", 32'(bus.dz), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        applyStimulus(143, 11, 13, 0, 0, 0, 0);
        applyStimulus(-100, 7, 'h32, 'h3E, 0, 0, 0);
        applyStimulus(500, 0, 0, 0, 1, 0, 0);
        applyStimulus(-2048, -1, 'h00, 0, 0, 1, 0);
        applyStimulus(100, 1, 'h24, 0, 0, 1, 0);
        applyStimulus(17, -5, 'h3D, 2, 0, 0, 0);
        applyStimulus(-17, -5, 3, 'h3E, 0, 0, 0);
        applyStimulus(2047, -32, 'h01, 'h1F, 0, 1, 0);
        applyStimulus(-2048, -32, 'h00, 0, 0, 1, 0);
        applyStimulus(-32, 31, 'h3F, 'h3F, 0, 0, 0);
        applyStimulus(0, 5, 0, 0, 0, 0, 0);
        applyStimulus(31, -32, 0, 31, 0, 0, 0);

        $display("[TB] start re-pulsed while busy");
        applyStimulus(143, 11, 13, 0, 0, 0, 1);

        $display("[TB] reset during operation");
        applyStimulus(-100, 7, 0, 0, 0, 0, 2);
        applyStimulus(-100, 7, 'h32, 'h3E, 0, 0, 0);

        $display("[TB] round trip over all operand pairs");
        for (int a = -32; a <= 31; a++) begin
            for (int b = -32; b <= 31; b++) begin
                if (b != 0) applyStimulus(a * b, b, a, 0, 0, 0, 0);
            end
        end

        repeat (5) @(negedge clk);
        checkOutput("pending_results", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
